// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side byte buffer.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    GAP
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter handshake of the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_en;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        count;
  logic                   overflow;
  logic                   tx_active;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   transmit;

  modport master (
    output wr_data, wr_en, tx_active,
    input  full, empty, count, overflow, tx_data, transmit
  );

  modport slave (
    input  wr_data, wr_en, tx_active,
    output full, empty, count, overflow, tx_data, transmit
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a one-cycle overflow pulse.
module sync_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  wr_ptr_nxt;
  logic [ADDR_W:0]  rd_ptr_nxt;
  logic [ADDR_W:0]  count_nxt;
  logic             do_wr;
  logic             do_rd;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (do_wr) wr_ptr_nxt = wr_ptr + (ADDR_W+1)'(1);
    if (do_rd) rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(1);
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == (ADDR_W+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding one frame at a time to the UART transmitter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  tx_fifo_state_t         state;
  logic                   pop;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_overflow;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = fifo_overflow;

  // Registered empty means a byte written this cycle is seen by IDLE one cycle later.
  assign pop = (state == IDLE) && !fifo_empty && !bus.tx_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.tx_data  <= '0;
      bus.transmit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.tx_data  <= rd_data;
            bus.transmit <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (bus.tx_active) begin
            bus.transmit <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.tx_active) state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          bus.transmit <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle table for a single frame plus directed corner sequences.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       txa;
    logic       e_tr;
    logic [7:0] e_td;
    logic [4:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       manual_txa = 1'b0;
  logic       model_en   = 1'b0;
  logic       model_txa  = 1'b0;
  int         busy_cnt   = 0;
  int         gap_cnt    = 100;
  logic [7:0] cap_q[$];
  int         gap_q[$];
  vec_t       vecs[$];

  assign bus.tx_active = model_en ? model_txa : manual_txa;

  // Transmitter model: accepts a request, stays busy a few cycles, and records the idle gap before each frame.
  always @(negedge clk) begin
    if (!model_en) begin
      model_txa = 1'b0;
      busy_cnt  = 0;
    end else if (model_txa) begin
      if (busy_cnt > 0) busy_cnt--;
      else model_txa = 1'b0;
    end else if (bus.transmit) begin
      cap_q.push_back(bus.tx_data);
      gap_q.push_back(gap_cnt);
      gap_cnt   = 0;
      model_txa = 1'b1;
      busy_cnt  = 4;
    end else begin
      gap_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic txa);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = d;
    manual_txa  = txa;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    manual_txa  = 1'b0;
    model_en    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic txa,
                              input logic tr, input logic [7:0] td, input logic [4:0] cnt,
                              input logic emp);
    vec_t v;
    v.we = we;  v.wd = wd;  v.txa = txa;
    v.e_tr = tr;  v.e_td = td;  v.e_cnt = cnt;
    v.e_empty = emp;  v.e_full = 1'b0;  v.e_ovf = 1'b0;
    return v;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;

    // Single A5 frame, transmitter rises one cycle after transmit and stays busy 20 cycles.
    vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1));

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    doReset();

    checkOutput("reset.empty",    32'(bus.empty),    32'd1);
    checkOutput("reset.count",    32'(bus.count),    32'd0);
    checkOutput("reset.full",     32'(bus.full),     32'd0);
    checkOutput("reset.overflow", 32'(bus.overflow), 32'd0);
    checkOutput("reset.transmit", 32'(bus.transmit), 32'd0);
    checkOutput("reset.tx_data",  32'(bus.tx_data),  32'h00);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("idle[%0d].transmit", i), 32'(bus.transmit), 32'd0);
    end
    checkOutput("idle.empty", 32'(bus.empty), 32'd1);

    $display("[TB] single-byte table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].txa);
      checkOutput($sformatf("a5[%0d].transmit", i), 32'(bus.transmit), 32'(vecs[i].e_tr));
      checkOutput($sformatf("a5[%0d].tx_data", i),  32'(bus.tx_data),  32'(vecs[i].e_td));
      checkOutput($sformatf("a5[%0d].count", i),    32'(bus.count),    32'(vecs[i].e_cnt));
      checkOutput($sformatf("a5[%0d].empty", i),    32'(bus.empty),    32'(vecs[i].e_empty));
      checkOutput($sformatf("a5[%0d].full", i),     32'(bus.full),     32'(vecs[i].e_full));
      checkOutput($sformatf("a5[%0d].overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
    end

    $display("[TB] burst 01..05");
    doReset();
    model_en = 1'b1;
    base = cap_q.size();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i + 1), 1'b0);
    for (int k = 0; k < 400 && (cap_q.size() - base) < 5; k++) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("burst.frames", 32'(cap_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < cap_q.size()) begin
        checkOutput($sformatf("burst[%0d].byte", i), 32'(cap_q[base + i]), 32'(i + 1));
        checkOutput($sformatf("burst[%0d].gap_ge2", i), 32'(gap_q[base + i] >= 2), 32'd1);
      end
    end
    checkOutput("burst.empty", 32'(bus.empty), 32'd1);

    $display("[TB] overflow with transmitter held busy");
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b1);
      checkOutput($sformatf("ovf[%0d].count", i),    32'(bus.count),    32'((i + 1 > 16) ? 16 : i + 1));
      checkOutput($sformatf("ovf[%0d].full", i),     32'(bus.full),     32'(i >= 15));
      checkOutput($sformatf("ovf[%0d].overflow", i), 32'(bus.overflow), 32'(i == 16));
      checkOutput($sformatf("ovf[%0d].transmit", i), 32'(bus.transmit), 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf.pulse_end", 32'(bus.overflow), 32'd0);
    checkOutput("ovf.hold_count", 32'(bus.count), 32'd16);
    model_en = 1'b1;
    base = cap_q.size();
    for (int k = 0; k < 800 && (cap_q.size() - base) < 16; k++) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf.frames", 32'(cap_q.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < cap_q.size())
        checkOutput($sformatf("ovf.drain[%0d]", i), 32'(cap_q[base + i]), 32'(8'h40 + i));
    end
    checkOutput("ovf.drain_empty", 32'(bus.empty), 32'd1);

    $display("[TB] reset during BUSY");
    doReset();
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("rb.launch", 32'(bus.transmit), 32'd1);
    applyStimulus(1'b1, 8'h33, 1'b1);
    applyStimulus(1'b1, 8'h44, 1'b1);
    checkOutput("rb.queued", 32'(bus.count), 32'd3);
    checkOutput("rb.busy_transmit", 32'(bus.transmit), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rb.transmit", 32'(bus.transmit), 32'd0);
    checkOutput("rb.count",    32'(bus.count),    32'd0);
    checkOutput("rb.empty",    32'(bus.empty),    32'd1);
    manual_txa = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_en = 1'b1;
    base = cap_q.size();
    applyStimulus(1'b1, 8'h3C, 1'b0);
    for (int k = 0; k < 100 && (cap_q.size() - base) < 1; k++) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (60) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rb.frames", 32'(cap_q.size() - base), 32'd1);
    if (cap_q.size() > base) checkOutput("rb.byte", 32'(cap_q[base]), 32'h3C);

    $display("[TB] LAUNCH stall");
    doReset();
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h6B, 1'b0);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("stall[%0d].transmit", i), 32'(bus.transmit), 32'd1);
      checkOutput($sformatf("stall[%0d].tx_data", i),  32'(bus.tx_data),  32'h5A);
      checkOutput($sformatf("stall[%0d].count", i),    32'(bus.count),    32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
